// File: rtl/sigmoid_sched.sv
// ============================================================================
// Module   : sigmoid_sched
// Purpose  : Round-robin scheduler sharing one fast-sigmoid unit among NREQ
//            requesters, with a done-arming rule and a completion watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmoid_sched #(
  parameter int S       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [S*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [S-1:0]      rsp_y,
  output logic              rsp_err,
  output logic              sig_start,
  output logic [S-1:0]      sig_x,
  input  logic [S-1:0]      sig_y,
  input  logic              sig_done,
  output logic              busy
);

  localparam int          PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam bit          WDOG_EN  = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     gnt_q;
  logic              armed_q;
  logic [15:0]       timer_q;
  logic              sig_start_q;
  logic [S-1:0]      sig_x_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [S-1:0]      rsp_y_q;
  logic              rsp_err_q;

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_rot;
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [PW:0]       w_sum;
  logic [S-1:0]      w_xsel;
  logic [PW-1:0]     w_ptr_next;

  // Rotating a doubled copy puts requester ptr at bit 0, so the first set
  // bit of the low half is the round-robin winner's offset from ptr.
  assign w_dbl = {req_valid, req_valid};
  assign w_rot = w_dbl >> ptr_q;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, ptr_q} + (PW+1)'(k);
        if (w_sum >= (PW+1)'(NREQ)) begin
          w_sum = w_sum - (PW+1)'(NREQ);
        end
        w_win = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_xsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_xsel = req_x[S*i +: S];
      end
    end
  end

  assign w_ptr_next = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);

  assign req_ready = (rst_n && (state_q == IDLE) && w_found) ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      armed_q     <= 1'b0;
      timer_q     <= '0;
      sig_start_q <= 1'b0;
      sig_x_q     <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      sig_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (w_found) begin
            gnt_q       <= w_win;
            sig_x_q     <= w_xsel;
            sig_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          armed_q <= 1'b0;
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_q + 16'd1;
          if (!sig_done) begin
            armed_q <= 1'b1;
          end
          // A done level seen before it has been low once belongs to the
          // previous operation; a genuine done beats a same-cycle timeout.
          if (armed_q && sig_done) begin
            rsp_y_q     <= sig_y;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= NREQ'(1) << gnt_q;
            state_q     <= RESP;
          end else if (WDOG_EN && (timer_q == TMO_LAST)) begin
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NREQ'(1) << gnt_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          ptr_q   <= w_ptr_next;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign sig_start = sig_start_q;
  assign sig_x     = sig_x_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_sched.sv
// ============================================================================
// Module   : tb_sigmoid_sched
// Purpose  : Scoreboard bench for sigmoid_sched with a behavioural unit model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sigmoid_sched;

  localparam int S    = 32;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [S*NREQ-1:0] req_x = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [S-1:0]      rsp_y;
  logic              rsp_err;
  logic              sig_start;
  logic [S-1:0]      sig_x;
  logic [S-1:0]      sig_y = '0;
  logic              sig_done = 1'b1;
  logic              busy;

  always #5 clk = ~clk;

  sigmoid_sched #(.S(S), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .sig_start (sig_start),
    .sig_x     (sig_x),
    .sig_y     (sig_y),
    .sig_done  (sig_done),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Hand-computed fast sigmoid 0.5*x/(1+|x|)+0.5 for the operands used here.
  function automatic logic [31:0] fast_sig(input logic [31:0] x);
    case (x)
      32'h40000000: return 32'h3F555555;
      32'h3F800000: return 32'h3F400000;
      32'hBF800000: return 32'h3E800000;
      32'hC0000000: return 32'h3E2AAAAB;
      32'h00000000: return 32'h3F000000;
      32'h00000001: return 32'h3F000000;
      32'h7FC00000: return 32'h7FC00000;
      default:      return 32'hBAD0BAD0;
    endcase
  endfunction

  typedef struct {
    logic [NREQ-1:0] who;
    logic [31:0]     y;
    logic            err;
    int              lat;
  } exp_t;

  exp_t        exp_rsp_q[$];
  logic [31:0] exp_st_q[$];

  logic [31:0] x_tab [NREQ][16];
  int          nreq [NREQ];
  int          nidx [NREQ];
  bit          acc_pend = 1'b0;
  int          acc_i = 0;

  task automatic add_op(input int i, input logic [31:0] x);
    x_tab[i][nreq[i]] = x;
    nreq[i]++;
    exp_st_q.push_back(x);
  endtask

  task automatic add_req(input int i, input logic [31:0] x, input logic err, input int lat);
    exp_t e;
    add_op(i, x);
    e.who = NREQ'(1) << i;
    e.y   = err ? 32'h0 : fast_sig(x);
    e.err = err;
    e.lat = lat;
    exp_rsp_q.push_back(e);
  endtask

  // Requester side: hold each operand until its accept edge, then advance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc_pend) begin
        nidx[acc_i]++;
        acc_pend = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]     = (nidx[i] < nreq[i]);
        req_x[S*i +: S]  = (nidx[i] < nreq[i]) ? x_tab[i][nidx[i]] : '0;
      end
    end
  end

  // Shared-unit model: 0 = normal, 1 = stale done first, 2 = never completes.
  int m_mode = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (sig_start) begin
        case (m_mode)
          0: begin
            sig_done = 1'b0;
            repeat (5) @(negedge clk);
            sig_y    = fast_sig(sig_x);
            sig_done = 1'b1;
          end
          1: begin
            sig_y = 32'hDEADBEEF;
            repeat (4) @(negedge clk);
            sig_done = 1'b0;
            @(negedge clk);
            sig_y    = fast_sig(sig_x);
            sig_done = 1'b1;
          end
          default: sig_done = 1'b0;
        endcase
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          start_cyc = 0;
  bit          prev_start = 1'b0;
  bit          in_rsp = 1'b0;
  logic [31:0] held_y = '0;
  logic        held_err = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
        chk("busy_in_idle", 32'(busy), 32'd0);
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) acc_i = i;
        acc_pend = 1'b1;
      end
      if (sig_start) begin
        chk("start_one_cycle", 32'(prev_start), 32'd0);
        chk("busy_in_issue", 32'(busy), 32'd1);
        if (exp_st_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_start: got sig_x %h, required no start", sig_x);
        end else begin
          chk("sig_x", sig_x, exp_st_q.pop_front());
        end
        start_cyc = cyc;
      end
      prev_start = sig_start;
      if (rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid %b, required none", rsp_valid);
        end else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(e.who));
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - start_cyc), 32'(e.lat));
          chk("busy_in_resp", 32'(busy), 32'd1);
        end
        held_y   = rsp_y;
        held_err = rsp_err;
        in_rsp   = 1'b1;
      end else if (in_rsp) begin
        chk("rsp_y_hold", rsp_y, held_y);
        chk("rsp_err_hold", 32'(rsp_err), 32'(held_err));
        in_rsp = 1'b0;
      end
    end
  end

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NREQ; i++) p += nreq[i] - nidx[i];
    return p;
  endfunction

  task automatic wait_idle(input int max);
    bit ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (exp_rsp_q.size() == 0 && !busy && !acc_pend && pending() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: got %0d responses outstanding after %0d cycles, required 0",
               exp_rsp_q.size(), max);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_y"}, rsp_y, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_sig_start"}, 32'(sig_start), 32'd0);
    chk({tag, "_sig_x"}, sig_x, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    // Reset state, with requester 0 already valid so ready gating is visible.
    m_mode = 0;
    add_req(0, 32'h40000000, 1'b0, 6);
    repeat (3) @(negedge clk);
    chk("rst_req_valid_driven", 32'(req_valid), 32'b0001);
    chk_all_zero("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(200);

    // All four at once after a fresh reset: strict 0,1,2,3 order.
    reset_pulse();
    add_req(0, 32'h3F800000, 1'b0, 6);
    add_req(1, 32'hBF800000, 1'b0, 6);
    add_req(2, 32'hC0000000, 1'b0, 6);
    add_req(3, 32'h40000000, 1'b0, 6);
    wait_idle(300);

    // Fairness between 0 and 2 with continuous valid.
    add_req(0, 32'h3F800000, 1'b0, 6);
    add_req(2, 32'h40000000, 1'b0, 6);
    add_req(0, 32'hBF800000, 1'b0, 6);
    add_req(2, 32'h7FC00000, 1'b0, 6);
    add_req(0, 32'hC0000000, 1'b0, 6);
    add_req(2, 32'h00000001, 1'b0, 6);
    add_req(0, 32'h00000000, 1'b0, 6);
    add_req(2, 32'h3F800000, 1'b0, 6);
    wait_idle(400);

    // Stale done held from the previous operation.
    m_mode = 1;
    add_req(1, 32'h00000000, 1'b0, 6);
    wait_idle(200);

    // Watchdog, then a normal operation afterwards.
    m_mode = 2;
    add_req(0, 32'hBF800000, 1'b1, 17);
    wait_idle(200);
    m_mode = 0;
    add_req(1, 32'h7FC00000, 1'b0, 6);
    wait_idle(200);

    // Reset while waiting: in-flight request vanishes, requester 3 goes next.
    m_mode = 2;
    add_op(2, 32'h3F800000);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sig_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reset_test_started", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    chk("reset_test_busy_before", 32'(busy), 32'd1);
    m_mode = 0;
    add_req(3, 32'h00000001, 1'b0, 6);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(200);

    repeat (5) @(negedge clk);
    chk("leftover_rsp", 32'(exp_rsp_q.size()), 32'd0);
    chk("leftover_start", 32'(exp_st_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL global_timeout: got no completion, required $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
